// File: rtl/mac_bias_pipe.sv
// mac_bias_pipe: gated multiply-accumulate with bias, LANES pixels per cycle.
//
// One operand set (S spike bits, S signed weights, one signed bias) is accepted
// in IDLE. acc is loaded with the sign-extended bias, and then for
// BEATS = ceil(S/LANES) cycles the weights of the active pixels in the current
// lane group are added to it. The result is converted to OUT_WIDTH bits and held
// in DONE until the consumer accepts it.
//
// Optional feature macro: MAC_BIAS_SAT_EN
//   defined   -> final_out saturates to the signed OUT_WIDTH range
//   undefined -> final_out is acc truncated to OUT_WIDTH bits (two's-complement wrap)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set valid
//   in_ready   block can accept operands (IDLE only)
//   bias       signed bias, WIDTH bits
//   pixels     S spike bits; bit i gates weight i
//   weights    S signed weights; weight i at [i*WIDTH +: WIDTH]
//   out_valid  final_out valid (DONE)
//   out_ready  consumer accepts the result
//   final_out  signed result, OUT_WIDTH bits
//   busy       high in any state other than IDLE
module mac_bias_pipe #(
    parameter int S         = 25,
    parameter int WIDTH     = 8,
    parameter int LANES     = 5,
    parameter int OUT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     bias,
    input  logic [S-1:0]                pixels,
    input  logic [S*WIDTH-1:0]          weights,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] final_out,
    output logic                        busy
);

    localparam int BEATS  = (S + LANES - 1) / LANES;
    localparam int PADN   = BEATS * LANES;
    localparam int PADW   = PADN * WIDTH;
    localparam int ACC_W  = WIDTH + $clog2(S + 1) + 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef MAC_BIAS_SAT_EN
    localparam longint OUT_MAX = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
    localparam longint OUT_MIN = -(64'sd1 <<< (OUT_WIDTH - 1));
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                        state_q, state_d;
    logic [S-1:0]                  pix_q, pix_d;
    logic [S*WIDTH-1:0]            w_q, w_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic signed [OUT_WIDTH-1:0]   final_q, final_d;

    logic [PADN-1:0]               pix_pad;
    logic [PADW-1:0]               w_pad;
    logic signed [ACC_W-1:0]       beat_sum;

    function automatic logic signed [OUT_WIDTH-1:0] to_out(input logic signed [ACC_W-1:0] a);
`ifdef MAC_BIAS_SAT_EN
        longint v;
        v = longint'(a);
        if (v > OUT_MAX) return OUT_WIDTH'(OUT_MAX);
        if (v < OUT_MIN) return OUT_WIDTH'(OUT_MIN);
        return OUT_WIDTH'(a);
`else
        return OUT_WIDTH'(a);
`endif
    endfunction

    // Zero-extend the captured operands to a whole number of beats so the last,
    // partially filled lane group reads zeros instead of out-of-range bits.
    assign pix_pad = PADN'(pix_q);
    assign w_pad   = PADW'(w_q);

    // Sum of the gated, sign-extended weights of the lane group selected by beat_q.
    always_comb begin
        beat_sum = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (pix_pad[b*LANES + l]) begin
                        beat_sum = beat_sum
                                 + ACC_W'($signed(w_pad[(b*LANES + l)*WIDTH +: WIDTH]));
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        w_d     = w_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        final_d = final_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pix_d   = pixels;
                    w_d     = weights;
                    acc_d   = ACC_W'(bias);
                    beat_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d  = acc_q + beat_sum;
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    final_d = to_out(acc_d);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pix_q   <= '0;
            w_q     <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            final_q <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            w_q     <= w_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            final_q <= final_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign final_out = final_q;

endmodule

// File: tb/tb_mac_bias_pipe.sv
// Testbench for mac_bias_pipe: two instances (LANES=5 and LANES=7, S=25) fed the
// same operands; results are checked against an integer reference model.
module tb_mac_bias_pipe;

    localparam int S     = 25;
    localparam int W     = 8;
    localparam int OW    = 8;
    // Edges counted from and including the accepting edge until out_valid is seen.
    localparam int LAT_A = (S + 5 - 1) / 5 + 1;
    localparam int LAT_B = (S + 7 - 1) / 7 + 1;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 out_ready;
    logic signed [W-1:0]  bias;
    logic [S-1:0]         pixels;
    logic [S*W-1:0]       weights;

    logic                 in_ready_a, out_valid_a, busy_a;
    logic signed [OW-1:0] final_a;
    logic                 in_ready_b, out_valid_b, busy_b;
    logic signed [OW-1:0] final_b;

    int checks = 0;
    int errors = 0;

    mac_bias_pipe #(.S(S), .WIDTH(W), .LANES(5), .OUT_WIDTH(OW)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .bias      (bias),
        .pixels    (pixels),
        .weights   (weights),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .final_out (final_a),
        .busy      (busy_a)
    );

    mac_bias_pipe #(.S(S), .WIDTH(W), .LANES(7), .OUT_WIDTH(OW)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .bias      (bias),
        .pixels    (pixels),
        .weights   (weights),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .final_out (final_b),
        .busy      (busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer sum, then wrap or clamp to OW bits.
    function automatic int model(input logic [S-1:0] p, input logic [S*W-1:0] w,
                                 input logic signed [W-1:0] b);
        int sum;
        logic signed [W-1:0] wi;
        sum = int'(b);
        for (int i = 0; i < S; i++) begin
            wi = w[i*W +: W];
            if (p[i]) sum += int'(wi);
        end
`ifdef MAC_BIAS_SAT_EN
        if (sum > (1 << (OW - 1)) - 1) sum = (1 << (OW - 1)) - 1;
        if (sum < -(1 << (OW - 1)))    sum = -(1 << (OW - 1));
`else
        sum = sum % (1 << OW);
        if (sum < 0) sum += (1 << OW);
        if (sum >= (1 << (OW - 1))) sum -= (1 << OW);
`endif
        return sum;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rand_ops(output logic [S-1:0] p, output logic [S*W-1:0] w,
                            output logic signed [W-1:0] b);
        p = S'($urandom);
        for (int i = 0; i < S; i++) w[i*W +: W] = W'($urandom);
        b = W'($urandom);
    endtask

    // Called just after a negedge; returns just after a negedge with both DUTs idle.
    task automatic run(input string tag, input logic [S-1:0] p, input logic [S*W-1:0] w,
                       input logic signed [W-1:0] b);
        int  exp;
        int  n;
        int  lat_a;
        int  lat_b;
        bit  got_a;
        bit  got_b;
        exp = model(p, w, b);
        chk({tag, "_rdy_a"}, int'(in_ready_a), 1);
        chk({tag, "_rdy_b"}, int'(in_ready_b), 1);
        pixels    = p;
        weights   = w;
        bias      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        n = 1; got_a = 0; got_b = 0; lat_a = 0; lat_b = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!(got_a && got_b) && n < 30) begin
            if (out_valid_a && !got_a) begin
                got_a = 1; lat_a = n;
                chk({tag, "_out_a"}, int'(final_a), exp);
            end
            if (out_valid_b && !got_b) begin
                got_b = 1; lat_b = n;
                chk({tag, "_out_b"}, int'(final_b), exp);
            end
            if (!(got_a && got_b)) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
        end
        chk({tag, "_got_a"}, int'(got_a), 1);
        chk({tag, "_got_b"}, int'(got_b), 1);
        chk({tag, "_lat_a"}, lat_a, LAT_A);
        chk({tag, "_lat_b"}, lat_b, LAT_B);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop_a"}, int'(out_valid_a), 0);
    endtask

    initial begin
        logic [S-1:0]        p;
        logic [S*W-1:0]      w;
        logic signed [W-1:0] b;
        int                  exp;
        int                  held;
        int                  n;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        bias = '0; pixels = '0; weights = '0;
        #3;
        chk("rst_rdy_a",   int'(in_ready_a),  1);
        chk("rst_vld_a",   int'(out_valid_a), 0);
        chk("rst_busy_a",  int'(busy_a),      0);
        chk("rst_final_a", int'(final_a),     0);
        chk("rst_rdy_b",   int'(in_ready_b),  1);
        chk("rst_vld_b",   int'(out_valid_b), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset release accepts; latency check in run covers it.
        run("bias_only", '0, '0, 8'sd5);

        for (int i = 0; i < S; i++) w[i*W +: W] = 8'd1;
        run("all_ones", '1, w, 8'sd0);

        for (int i = 0; i < S; i++) w[i*W +: W] = 8'd127;
        run("overflow", '1, w, 8'sd127);

        w = '0;
        w[24*W +: W] = 8'hFD;
        run("pix24", S'(1) << 24, w, 8'sd1);

        for (int k = 0; k < 15; k++) begin
            rand_ops(p, w, b);
            run($sformatf("rnd%0d", k), p, w, b);
        end

        // Backpressure in DONE with in_valid toggling new data.
        rand_ops(p, w, b);
        exp = model(p, w, b);
        pixels = p; weights = w; bias = b;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid_a && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("bp_valid_a", int'(out_valid_a), 1);
        chk("bp_lat_a",   n, LAT_A);
        chk("bp_out_a",   int'(final_a), exp);
        chk("bp_valid_b", int'(out_valid_b), 1);
        chk("bp_out_b",   int'(final_b), exp);
        held = int'(final_a);
        for (int k = 0; k < 10; k++) begin
            rand_ops(p, w, b);
            pixels = p; weights = w; bias = b;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_vld", int'(out_valid_a), 1);
            chk("bp_hold_out", int'(final_a),     held);
            chk("bp_hold_rdy", int'(in_ready_a),  0);
        end
        chk("bp_hold_out_b", int'(final_b), exp);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_rel_vld_a",  int'(out_valid_a), 0);
        chk("bp_rel_rdy_a",  int'(in_ready_a),  1);
        chk("bp_rel_busy_a", int'(busy_a),      0);
        chk("bp_rel_vld_b",  int'(out_valid_b), 0);

        // Reset in the middle of accumulation (beat 2 of the LANES=5 instance).
        rand_ops(p, w, b);
        pixels = p; weights = w; bias = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_pre", int'(busy_a), 1);
        rst = 1'b1;
        #1;
        chk("abort_vld_a",   int'(out_valid_a), 0);
        chk("abort_busy_a",  int'(busy_a),      0);
        chk("abort_rdy_a",   int'(in_ready_a),  1);
        chk("abort_final_a", int'(final_a),     0);
        chk("abort_busy_b",  int'(busy_b),      0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_no_pulse", int'(out_valid_a), 0);
        w = '0;
        w[0 +: W] = 8'hFC;
        run("after_abort", S'(1), w, 8'sd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
